// File: rtl/qspi_pkg.sv
// +----------------------------------------------------------------------+
// | qspi_pkg : shared types, opcodes and beat counts for qspi_mem_ctrl   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_DATA_RD = 3'd4,
    ST_DATA_WR = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [7:0] DEF_CMD_READ  = 8'hEB;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h38;

  localparam int CMD_Q      = 2;
  localparam int CMD_S      = 8;
  localparam int ADDR_BEATS = 6;
  localparam int DATA_BEATS = 8;

  // 00->4, 01->6, 10->8, 11->10 dummy beats
  function automatic logic [3:0] dummy_beats(input logic [1:0] lat);
    return 4'd4 + {1'b0, lat, 1'b0};
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_mem_ctrl_if.sv
// +----------------------------------------------------------------------+
// | qspi_mem_ctrl_if : SoC-side request/response bus of qspi_mem_ctrl    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface qspi_mem_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_cs;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_cs, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_cs, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

`default_nettype wire

// File: rtl/qspi_nibble_shifter.sv
// +----------------------------------------------------------------------+
// | qspi_nibble_shifter : 32-bit nibble shifter, little-endian bytes,    |
// | high nibble first within each byte.  Revision : 1.0                  |
// +----------------------------------------------------------------------+
`default_nettype none

module qspi_nibble_shifter
  import qspi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_out,
  input  logic        shift_in,
  input  logic [3:0]  nib_in,
  output logic [3:0]  nib_out,
  output logic [31:0] rd_word
);
  // Byte-swapped storage turns the wire order into plain MSB-first nibbles
  logic [31:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      sh <= byte_swap(load_data);
    end else if (shift_in) begin
      sh <= {sh[27:0], nib_in};
    end else if (shift_out) begin
      sh <= {sh[27:0], 4'h0};
    end
  end

  assign nib_out = sh[31:28];
  // Includes the nibble being sampled now, so the word is complete on the last beat
  assign rd_word = byte_swap({sh[27:0], nib_in});

endmodule

`default_nettype wire

// File: rtl/qspi_mem_ctrl.sv
// +----------------------------------------------------------------------+
// | qspi_mem_ctrl : 32-bit word requests to quad-SPI PSRAM/flash cycles  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module qspi_mem_ctrl
  import qspi_pkg::*;
#(
  parameter int         ADDR_W    = 24,
  parameter int         NUM_CS    = 3,
  parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE
)(
  input  logic              clk,
  input  logic              rst_n,
  qspi_mem_ctrl_if.slave    bus,
  input  logic              init_qspicmd,
  input  logic [1:0]        init_latency,
  output logic              sck,
  output logic [NUM_CS-1:0] ce_n,
  output logic [3:0]        sio_o,
  input  logic [3:0]        sio_i,
  output logic              sio_en
);
  localparam int         HDR_W     = 8 + ADDR_W;
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_W / 4 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BEATS - 1);

  state_t            state;
  logic              phase;
  logic [3:0]        beat;
  logic [3:0]        dummy_last;
  logic              we_q;
  logic              qcmd_q;
  logic [HDR_W-1:0]  hdr;
  logic [NUM_CS-1:0] cs_sel;
  logic              cs_ok;
  logic              accept;
  logic [HDR_W-1:0]  hdr_init;
  logic [3:0]        cmd_last;
  logic              shift_out;
  logic              shift_in;
  logic [3:0]        nib_out;
  logic [31:0]       rd_word;

  always_comb begin
    cs_sel = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(bus.req_cs) == i) cs_sel[i] = 1'b1;
    end
    cs_ok = int'(bus.req_cs) < NUM_CS;
  end

  assign accept    = (state == ST_IDLE) && bus.req_valid && bus.req_ready;
  assign hdr_init  = {bus.req_we ? CMD_WRITE : CMD_READ, bus.req_addr};
  assign cmd_last  = qcmd_q ? 4'(CMD_Q - 1) : 4'(CMD_S - 1);
  // Both act on the edge that ends phase H
  assign shift_in  = phase && (state == ST_DATA_RD);
  assign shift_out = phase && (((state == ST_ADDR) && (beat == ADDR_LAST) && we_q) ||
                               ((state == ST_DATA_WR) && (beat != DATA_LAST)));

  qspi_nibble_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (bus.req_wdata),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .nib_in    (sio_i),
    .nib_out   (nib_out),
    .rd_word   (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      phase         <= 1'b0;
      beat          <= '0;
      dummy_last    <= '0;
      we_q          <= 1'b0;
      qcmd_q        <= 1'b0;
      hdr           <= '0;
      sck           <= 1'b0;
      ce_n          <= '1;
      sio_o         <= '0;
      sio_en        <= 1'b0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (accept) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            qcmd_q        <= init_qspicmd;
            dummy_last    <= dummy_beats(init_latency) - 4'd1;
            phase         <= 1'b0;
            beat          <= '0;
            if (!cs_ok) begin
              state         <= ST_DONE;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else begin
              state  <= ST_CMD;
              ce_n   <= ~cs_sel;
              sio_en <= 1'b1;
              if (init_qspicmd) begin
                sio_o <= hdr_init[HDR_W-1 -: 4];
                hdr   <= hdr_init << 4;
              end else begin
                sio_o <= {3'b111, hdr_init[HDR_W-1]};
                hdr   <= hdr_init << 1;
              end
            end
          end
        end

        ST_DONE: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end

        default: begin
          if (!phase) begin
            phase <= 1'b1;
            sck   <= 1'b1;
          end else begin
            phase <= 1'b0;
            sck   <= 1'b0;
            beat  <= beat + 4'd1;
            case (state)
              ST_CMD: begin
                if (beat == cmd_last) begin
                  state <= ST_ADDR;
                  beat  <= '0;
                  sio_o <= hdr[HDR_W-1 -: 4];
                  hdr   <= hdr << 4;
                end else if (qcmd_q) begin
                  sio_o <= hdr[HDR_W-1 -: 4];
                  hdr   <= hdr << 4;
                end else begin
                  sio_o <= {3'b111, hdr[HDR_W-1]};
                  hdr   <= hdr << 1;
                end
              end
              ST_ADDR: begin
                if (beat == ADDR_LAST) begin
                  beat <= '0;
                  if (we_q) begin
                    state <= ST_DATA_WR;
                    sio_o <= nib_out;
                  end else begin
                    state  <= ST_DUMMY;
                    sio_en <= 1'b0;
                    sio_o  <= '0;
                  end
                end else begin
                  sio_o <= hdr[HDR_W-1 -: 4];
                  hdr   <= hdr << 4;
                end
              end
              ST_DUMMY: begin
                if (beat == dummy_last) begin
                  state <= ST_DATA_RD;
                  beat  <= '0;
                end
              end
              ST_DATA_RD: begin
                if (beat == DATA_LAST) begin
                  state         <= ST_DONE;
                  ce_n          <= '1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= rd_word;
                end
              end
              ST_DATA_WR: begin
                if (beat == DATA_LAST) begin
                  state         <= ST_DONE;
                  ce_n          <= '1;
                  sio_en        <= 1'b0;
                  sio_o         <= '0;
                  bus.rsp_valid <= 1'b1;
                end else begin
                  sio_o <= nib_out;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/qspi_mem_ctrl.md
Name: qspi_mem_ctrl

Overview:
- QSPI memory controller inside fpga_top, directly upstream of the top-level pads sck, ce_n[2:0], sio_o/sio_i/sio_en.
- Converts 32-bit word read/write requests from the SoC bus into quad-SPI transactions on PSRAM/flash.
- Command-phase width and read dummy count come from the init_qspicmd / init_latency straps.

Parameters:
- ADDR_W, 24, byte address width sent on the bus (6 nibbles at 24).
- NUM_CS, 3, number of chip selects.
- CMD_READ, 8'hEB, quad read opcode.
- CMD_WRITE, 8'h38, quad write opcode.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, accepts request
- req_we  in  1  1=write, 0=read
- req_cs  in  2  chip select index 0..2
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = invalid req_cs
- rsp_rdata  out  32  read data, held until next response
- init_qspicmd  in  1  1=command sent quad (2 beats), 0=single-bit on sio[0] (8 beats)
- init_latency  in  2  read dummy beats: 00→4, 01→6, 10→8, 11→10
- sck  out  1  SPI clock, clk/2
- ce_n  out  NUM_CS  active-low chip selects
- sio_o  out  4  quad data out
- sio_i  in  4  quad data in
- sio_en  out  1  output enable for all 4 sio lines

Behaviour:
- Reset (async, rst_n low): ce_n all 1, sck 0, sio_en 0, sio_o 0, req_ready 0 during reset (1 after), rsp_valid 0, rsp_err 0, rsp_rdata 0, state IDLE.
- Reset mid-transaction: ce_n deasserts immediately (async); no response is issued.
- Clocking:
  - One beat = 2 clk: phase L (sck=0), then phase H (sck=1).
  - Outputs update on the edge entering phase L.
  - sio_i is sampled on the edge ending phase H.
- States: IDLE → CMD → ADDR → [DUMMY → DATA_RD | DATA_WR] → DONE → IDLE.
- IDLE:
  - req_ready=1; accept on req_valid&req_ready.
  - req_we, req_cs, req_addr, req_wdata and both straps are latched at acceptance.
- Invalid cs (req_cs=3): go to DONE directly, no ce_n assertion; rsp_valid=1 and rsp_err=1 the cycle after acceptance.
- Transaction start: the cycle after acceptance, the selected ce_n goes low and the first beat's phase L begins.
- CMD:
  - Quad: 2 beats, high nibble first, sio_en=1.
  - Single: 8 beats, MSB first, sio_o={3'b111,bit}, sio_en=1.
- ADDR: 6 beats, nibbles MSB-first, sio_en=1.
- DUMMY (read only): N beats per init_latency, sio_en=0.
- DATA: 8 beats, little-endian bytes, high nibble first within each byte.
  - Order: wdata[7:4], [3:0], [15:12], ...
  - Write: sio_en=1. Read: sio_en=0, nibbles assembled in the same order.
- DONE:
  - 1 cycle; ce_n all 1, sck 0, sio_en 0, rsp_valid=1, rsp_rdata updated on reads (unchanged on writes).
  - Next cycle IDLE, so ce_n is high for ≥2 clk between transactions.
- Latency, acceptance edge to rsp_valid = 2·beats+1 clk:
  - quad-cmd read: beats = 2+6+N+8
  - quad-cmd write: beats = 16
  - single-cmd: +6 beats
- sck is 0 whenever ce_n is all high.
- req_valid during a transaction is ignored (req_ready=0).

Decomposition:
- Package qspi_pkg:
  - state enum
  - CMD_READ/CMD_WRITE defaults
  - beat-count constants (CMD_Q=2, CMD_S=8, ADDR_BEATS=6, DATA_BEATS=8)
  - dummy-latency lookup function
- Sub-module qspi_nibble_shifter: 32-bit shift register for load/shift-out/shift-in of nibbles with little-endian byte ordering. The top FSM owns beat/phase counters.

Test Plan:
- Reset mid-read (rst_n low at beat 10) → ce_n=3'b111 and sio_en=0 that instant; no rsp_valid; next request completes normally.
- Quad read, cs=0, addr 24'h123456, lat=00:
  - Stimulus: memory model returns bytes 11,22,33,44.
  - Required: sio_o sequence E,B,1,2,3,4,5,6, then 4 dummy beats with sio_en=0.
  - Required: rsp_rdata=32'h44332211; rsp_valid exactly 41 clk after acceptance.
- Quad write, cs=2, addr 24'h000010, data 32'hDEADBEEF:
  - Required: nibbles 3,8,0,0,0,0,1,0,E,F,B,E,A,D,D,E; ce_n=3'b011 during the transfer.
  - Required: rsp_valid at 33 clk.
- Single-cmd read, init_qspicmd=0, lat=11:
  - Required: sio_o[0] carries 1,1,1,0,1,0,1,1 with sio_o[3:1]=3'b111; 10 dummy beats.
  - Required: rsp_valid at 65 clk.
- req_cs=3 → no ce_n low, no sck toggles; rsp_valid=1 and rsp_err=1 one clk after acceptance; req_ready back 1 the following cycle.
- Back-to-back requests with req_valid held high → ce_n high ≥2 clk between them; second transaction latches its own strap values.
